// File: rtl/lsl8_seq_if.sv
// Handshake and result bundle for the iterative left shifter.
// The requester (master) drives start/operands; the shifter (slave) returns
// status and the registered result.
interface lsl8_seq_if #(
  parameter int WIDTH   = 8,
  parameter int SHAMT_W = 3
);
  logic               start;
  logic [WIDTH-1:0]   d_in;
  logic [SHAMT_W-1:0] shamt;
  logic               busy;
  logic               done;
  logic [WIDTH-1:0]   d_out;
  logic               carry;
  logic               zero;

  modport master (
    output start, d_in, shamt,
    input  busy, done, d_out, carry, zero
  );

  modport slave (
    input  start, d_in, shamt,
    output busy, done, d_out, carry, zero
  );
endinterface

// File: rtl/lsl8_seq.sv
// Iterative logical shift-left: one bit position per clock, start/done
// handshake. Latency is shamt+1 cycles from the accept edge; result,
// carry-out and zero flag hold until the next operation completes.
module lsl8_seq #(
  parameter int WIDTH   = 8,
  parameter int SHAMT_W = 3
) (
  input  logic          clk,
  input  logic          reset_n,
  lsl8_seq_if.slave     bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [WIDTH-1:0]   work;
  logic [SHAMT_W-1:0] cnt;
  logic [WIDTH-1:0]   d_out_r;
  logic               carry_r;

  // Single-position left shift, zero entering at the LSB.
  function automatic logic [WIDTH-1:0] shl1(input logic [WIDTH-1:0] v);
    return {v[WIDTH-2:0], 1'b0};
  endfunction

  // State register; reset aborts any operation in flight.
  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic: a zero shift skips straight to DONE.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (bus.start) begin
          if (bus.shamt == '0) state_nxt = DONE;
          else                 state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (cnt == SHAMT_W'(1)) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Working register, countdown and result registers. The running carry is
  // simply work's MSB before each shift, so it is captured into carry_r on
  // the final shift rather than kept in a separate register.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      work    <= '0;
      cnt     <= '0;
      d_out_r <= '0;
      carry_r <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            work <= bus.d_in;
            cnt  <= bus.shamt;
            if (bus.shamt == '0) begin
              d_out_r <= bus.d_in;
              carry_r <= 1'b0;
            end
          end
        end
        SHIFT: begin
          work <= shl1(work);
          cnt  <= cnt - SHAMT_W'(1);
          if (cnt == SHAMT_W'(1)) begin
            d_out_r <= shl1(work);
            carry_r <= work[WIDTH-1];
          end
        end
        default: ;
      endcase
    end
  end

  // Status outputs decode directly from state; zero tracks the held result.
  always_comb begin
    bus.busy  = (state == SHIFT) || (state == DONE);
    bus.done  = (state == DONE);
    bus.d_out = d_out_r;
    bus.carry = carry_r;
    bus.zero  = (d_out_r == '0);
  end

endmodule

// File: tb/tb_lsl8_seq.sv
// Scoreboard bench for lsl8_seq: stimulus pushes expected results computed
// from plain arithmetic; a negedge monitor pops and compares on each done.
module tb_lsl8_seq;

  logic clk = 1'b0;
  logic reset_n;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  lsl8_seq_if #(.WIDTH(8), .SHAMT_W(3)) bus ();

  lsl8_seq #(.WIDTH(8), .SHAMT_W(3)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] d;
    logic       c;
    logic       z;
    int         acc;
    int         sh;
  } exp_t;

  exp_t q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every done must match the oldest outstanding expectation.
  logic prev_done = 1'b0;
  always @(negedge clk) begin
    if (bus.done === 1'b1) begin
      if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done: done=1 with no outstanding op (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("d_out", {24'h0, bus.d_out}, {24'h0, e.d});
        chk("carry", {31'h0, bus.carry}, {31'h0, e.c});
        chk("zero", {31'h0, bus.zero}, {31'h0, e.z});
        chk("latency", cyc - e.acc, e.sh);
        chk("busy_in_done", {31'h0, bus.busy}, 32'd1);
      end
      if (prev_done) chk("done_single_pulse", {31'h0, prev_done}, 32'd0);
    end
    prev_done = (bus.done === 1'b1);
  end

  // Reference: bits shifted past bit 7 land in bit 8 and above; the last
  // one out is bit 8 of the widened product.
  function automatic exp_t model(input logic [7:0] d, input logic [2:0] s, input int acc);
    exp_t e;
    logic [15:0] full;
    full  = {8'h00, d} << s;
    e.d   = full[7:0];
    e.c   = (s == 3'd0) ? 1'b0 : full[8];
    e.z   = (full[7:0] == 8'h00);
    e.acc = acc;
    e.sh  = int'(s);
    return e;
  endfunction

  task automatic wait_done();
    int n = 0;
    while (bus.done !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (bus.done !== 1'b1) chk("done_timeout", 32'd0, 32'd1);
  endtask

  // Called at a negedge with the DUT idle; returns at a negedge with it idle.
  task automatic do_op(input logic [7:0] d, input logic [2:0] s);
    q.push_back(model(d, s, cyc + 1));
    bus.start = 1'b1;
    bus.d_in  = d;
    bus.shamt = s;
    @(negedge clk);
    bus.start = 1'b0;
    bus.d_in  = 8'($urandom);
    bus.shamt = 3'($urandom);
    chk("busy_after_accept", {31'h0, bus.busy}, 32'd1);
    wait_done();
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n   = 1'b0;
    bus.start = 1'b1;
    bus.d_in  = 8'hFF;
    bus.shamt = 3'd3;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", {31'h0, bus.busy}, 32'd0);
    chk("rst_done", {31'h0, bus.done}, 32'd0);
    chk("rst_d_out", {24'h0, bus.d_out}, 32'h00);
    chk("rst_carry", {31'h0, bus.carry}, 32'd0);
    chk("rst_zero", {31'h0, bus.zero}, 32'd1);
    bus.start = 1'b0;
    reset_n   = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_busy", {31'h0, bus.busy}, 32'd0);
    chk("idle_done", {31'h0, bus.done}, 32'd0);

    // Directed cases.
    do_op(8'hB5, 3'd3);
    do_op(8'h3C, 3'd0);
    do_op(8'hFF, 3'd7);
    do_op(8'h01, 3'd7);
    do_op(8'h10, 3'd4);

    // Start re-asserted while busy must be ignored.
    q.push_back(model(8'h03, 3'd5, cyc + 1));
    bus.start = 1'b1;
    bus.d_in  = 8'h03;
    bus.shamt = 3'd5;
    @(negedge clk);
    bus.d_in  = 8'hFF;
    bus.shamt = 3'd1;
    repeat (3) @(negedge clk);
    chk("held_during_shift", {24'h0, bus.d_out}, 32'h00);
    bus.start = 1'b0;
    wait_done();
    @(negedge clk);
    repeat (4) @(negedge clk);
    chk("result_held", {24'h0, bus.d_out}, 32'h60);

    // Reset in the middle of a shift: no done, outputs cleared.
    bus.start = 1'b1;
    bus.d_in  = 8'hAA;
    bus.shamt = 3'd6;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    chk("abort_busy", {31'h0, bus.busy}, 32'd0);
    chk("abort_d_out", {24'h0, bus.d_out}, 32'h00);
    chk("abort_carry", {31'h0, bus.carry}, 32'd0);
    chk("abort_zero", {31'h0, bus.zero}, 32'd1);
    reset_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("abort_idle", {31'h0, bus.busy}, 32'd0);

    // Immediate new op, then randomized back-to-back traffic.
    do_op(8'h81, 3'd1);
    for (int i = 0; i < 60; i++) begin
      do_op(8'($urandom), 3'($urandom));
      if ($urandom_range(3) == 0) repeat ($urandom_range(3)) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    chk("queue_drained", q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lsl8_seq.md
Name: lsl8_seq

Overview:
Iterative 8-bit logical shift-left unit with a start/done handshake. It shifts by one bit position per clock cycle, so the shift amount sets the latency. It is the left-shift counterpart to the team's combinational mux-based right shifter, and sits in the datapath where an area-cheap left shift is acceptable.

Parameters:
WIDTH, 8, data width in bits
SHAMT_W, 3, shift-amount width; legal shift range 0..2^SHAMT_W-1 (0..7)

Ports:
clk  input  1  system clock; all state updates on the rising edge
reset_n  input  1  synchronous active-low reset
start  input  1  request pulse; sampled only in IDLE
d_in  input  WIDTH  operand; captured on the accept edge
shamt  input  SHAMT_W  shift amount; captured on the accept edge
busy  output  1  high in SHIFT and DONE states
done  output  1  one-cycle completion pulse
d_out  output  WIDTH  result, d_in << shamt, zero-filled from the LSB
carry  output  1  last bit shifted out of the MSB; 0 if shamt==0
zero  output  1  high when d_out==0

Behaviour:
- Reset: reset_n low at a rising edge -> state=IDLE, working register=0, count=0, d_out=0, carry=0, zero=1, busy=0, done=0.
- Reset mid-operation aborts the operation: no done pulse, and d_out/carry are cleared.
- States: IDLE, SHIFT, DONE. Encoding is free; state is registered.
- IDLE: on an edge with start=1 (accept edge E0):
  - work <= d_in; cnt <= shamt; cy <= 0.
  - Next state is DONE if shamt==0, else SHIFT.
- IDLE with start=0: remain in IDLE.
- SHIFT: each edge:
  - work <= {work[WIDTH-2:0],1'b0}; cy <= work[WIDTH-1]; cnt <= cnt-1.
  - When cnt==1 on that edge -> DONE.
- Result registers load on the edge entering DONE: d_out <= final shifted value; carry <= final cy (including the shift performed on that same edge).
- zero is combinational from d_out.
- DONE: done=1 for exactly one cycle; next edge -> IDLE unconditionally.
- busy=1 in SHIFT and DONE, 0 in IDLE.
- Latency: done is high in the cycle following edge E(shamt), i.e. shamt+1 cycles after the accept edge. shamt=0 gives 1 cycle; shamt=7 gives 8 cycles.
- start while busy (SHIFT or DONE) is ignored, not queued. d_in/shamt changes after E0 have no effect.
- Back-to-back: a start asserted in the cycle after done (state IDLE) is accepted. Minimum issue interval is shamt+2 cycles.
- d_out/carry/zero hold their values from DONE until the next operation's DONE. They do not change during SHIFT.
- Shifting never wraps: bits leaving the MSB are discarded except the last, which is reported in carry. Zeros enter at the LSB.
- cnt is SHAMT_W bits wide and never underflows, because SHIFT is entered only with cnt>=1.

Test Plan:
1. Reset: hold reset_n=0 for 2 edges with start=1 -> busy=0, done=0, d_out=8'h00, carry=0, zero=1; after release with start=0, stays IDLE.
2. d_in=8'hB5, shamt=3, start pulse -> busy rises next cycle; done high exactly 4 cycles after the accept edge; d_out=8'hA8, carry=1, zero=0.
3. shamt=0 corner: d_in=8'h3C -> done 1 cycle after accept; d_out=8'h3C, carry=0.
4. shamt=7 corner:
   - d_in=8'hFF -> d_out=8'h80, carry=1, done after 8 cycles.
   - d_in=8'h01 -> d_out=8'h80, carry=0.
5. Zero flag: d_in=8'h10, shamt=4 -> d_out=8'h00, zero=1, carry=1.
6. Protocol abuse:
   - Re-assert start with d_in=8'hFF, shamt=1 during a busy shamt=5 operation on 8'h03 -> ignored; result d_out=8'h60, carry=0, single done.
   - Then pulse reset_n low mid-SHIFT of a new op -> no done; outputs cleared.
   - Then an immediate new op completes correctly.
